game2048_move_ctrl: RTL
=======================

GAME2048_MOVE_CTRL -- requirements
Module: game2048_move_ctrl

Interface
REQ-001 SHALL have parameter DONE_TIMEOUT, default 255, max cycles waited for dp_done per phase (watchdog only).
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports move_up, move_down, move_left, move_right, input, 1 each, debounced level-high direction buttons.
REQ-005 SHALL have port dp_start, output, 1, one-cycle pulse launching a datapath phase.
REQ-006 SHALL have port dp_op, output, 2, phase code: 00 SHIFT, 01 MERGE, 10 SPAWN, 11 CHECK.
REQ-007 SHALL have port dp_dir, output, 2, latched direction: 00 up, 01 down, 10 left, 11 right.
REQ-008 SHALL have port dp_done, input, 1, datapath phase-complete pulse.
REQ-009 SHALL have port dp_changed, input, 1, board-changed flag, valid with dp_done of SHIFT/MERGE.
REQ-010 SHALL have ports dp_win, dp_lose, input, 1 each, valid with dp_done of CHECK.
REQ-011 SHALL have ports busy, win, lose, wd_error, output, 1 each; move_count, output, 16; state, output, 3.

Function
REQ-012 SHALL implement states IDLE(0), SHIFT1(1), MERGE(2), SHIFT2(3), SPAWN(4), CHECK(5), OVER(6), driven on port state.
REQ-013 SHALL register any_prev = OR of the four move inputs every cycle; a move is accepted only in IDLE when OR is 1 and any_prev is 0.
REQ-014 SHALL resolve simultaneous presses at acceptance by priority up > down > left > right and latch the winner into dp_dir until the next acceptance.
REQ-015 SHALL ignore, never queue, edges occurring outside IDLE; a button held across return to IDLE is not re-accepted until released.
REQ-016 SHALL, on acceptance at edge N, enter SHIFT1 with dp_start=1 during the cycle after edge N.
REQ-017 SHALL assert dp_start only in the first cycle of each phase state, with dp_op matching that state.
REQ-018 SHALL sample dp_done only from the cycle after dp_start; dp_done in IDLE/OVER or coincident with dp_start is ignored.
REQ-019 SHALL sequence SHIFT1 -> MERGE -> SHIFT2 on dp_done, OR-accumulating dp_changed into an internal changed flag cleared at acceptance.
REQ-020 SHALL on SHIFT2 done go to SPAWN if changed=1, else directly to IDLE (no spawn, no CHECK, no count).
REQ-021 SHALL on SPAWN done go to CHECK and increment move_count, saturating at 0xFFFF.
REQ-022 SHALL on CHECK done set sticky win if dp_win, sticky lose if dp_lose; go to OVER if either is set, else IDLE.
REQ-023 SHALL remain in OVER, ignoring all moves and dp_done, until reset.
REQ-024 SHALL drive busy=1 in states 1-5, 0 in IDLE and OVER.

Reset
REQ-025 SHALL on reset_n low immediately force state IDLE, dp_start 0, dp_op 00, dp_dir 00, busy 0, win 0, lose 0, wd_error 0, move_count 0, any_prev 1, changed 0.
REQ-026 SHALL abort any in-progress phase on reset mid-operation without further dp_start pulses.
REQ-027 SHALL, with any_prev reset to 1, require buttons released after reset release before the first acceptance.

Configuration
REQ-028 SHALL, with macro MOVE_CTRL_WATCHDOG_EN defined, count cycles since dp_start in states 1-5 and, on reaching DONE_TIMEOUT without dp_done, return to IDLE and set sticky wd_error until reset.
REQ-029 SHALL, without MOVE_CTRL_WATCHDOG_EN, wait indefinitely for dp_done and tie wd_error to 0.

Verification
REQ-030 SHALL test: move_left rising, dp_done 2 cycles after each dp_start, dp_changed=1 on MERGE -> dp_op 00,01,00,10,11 sequence, dp_dir=10, move_count 0->1, back to IDLE.
REQ-031 SHALL test: move_up and move_right rising same cycle -> dp_dir=00; move_down pressed during SHIFT1 -> ignored, no second sequence.
REQ-032 SHALL test: dp_changed=0 throughout -> after SHIFT2 done returns to IDLE, no SPAWN/CHECK pulses, move_count unchanged.
REQ-033 SHALL test: dp_win=1 at CHECK done -> win=1, state=6, further presses give no dp_start until reset_n low.
REQ-034 SHALL test: reset_n low during MERGE -> all outputs at reset values asynchronously; held button after release not accepted until released and re-pressed.
REQ-035 SHALL test (MOVE_CTRL_WATCHDOG_EN, DONE_TIMEOUT=8): no dp_done after SHIFT1 start -> after 8 cycles state=0, wd_error=1.

Source files
------------

// File: rtl/game2048_move_ctrl.sv
// game2048_move_ctrl: sequences SHIFT/MERGE/SHIFT/SPAWN/CHECK datapath phases per accepted move.
// Optional done-watchdog enabled by defining MOVE_CTRL_WATCHDOG_EN.
module game2048_move_ctrl #(
    parameter int DONE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        move_up,
    input  logic        move_down,
    input  logic        move_left,
    input  logic        move_right,
    output logic        dp_start,
    output logic [1:0]  dp_op,
    output logic [1:0]  dp_dir,
    input  logic        dp_done,
    input  logic        dp_changed,
    input  logic        dp_win,
    input  logic        dp_lose,
    output logic        busy,
    output logic        win,
    output logic        lose,
    output logic        wd_error,
    output logic [15:0] move_count,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT1 = 3'd1,
        MERGE  = 3'd2,
        SHIFT2 = 3'd3,
        SPAWN  = 3'd4,
        CHECK  = 3'd5,
        OVER   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic        first_q, first_d;
    logic [1:0]  dir_q, dir_d;
    logic        changed_q, changed_d;
    logic        any_prev_q, any_prev_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;
    logic [15:0] count_q, count_d;
    logic        any_move, accept, done_ok, timeout, changed_all;
    logic [1:0]  prio_dir;

    assign any_move    = move_up | move_down | move_left | move_right;
    assign any_prev_d  = any_move;
    assign busy        = (state_q != IDLE) && (state_q != OVER);
    assign accept      = (state_q == IDLE) && any_move && !any_prev_q;
    // dp_done coinciding with our own dp_start belongs to no phase yet
    assign done_ok     = busy && !first_q && dp_done;
    assign prio_dir    = move_up ? 2'b00 : move_down ? 2'b01 : move_left ? 2'b10 : 2'b11;
    assign changed_all = changed_q | dp_changed;
    assign dp_start    = first_q;
    assign dp_dir      = dir_q;
    assign win         = win_q;
    assign lose        = lose_q;
    assign move_count  = count_q;
    assign state       = state_q;

    // phase code follows the current state
    always_comb begin
        dp_op = (state_q == MERGE) ? 2'b01 : (state_q == SPAWN) ? 2'b10 : (state_q == CHECK) ? 2'b11 : 2'b00;
    end

`ifdef MOVE_CTRL_WATCHDOG_EN
    localparam int CW = $clog2(DONE_TIMEOUT + 1);
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          wd_error_q, wd_error_d;

    assign timeout  = busy && !done_ok && (wd_cnt_q + CW'(1) == CW'(DONE_TIMEOUT));
    assign wd_error = wd_error_q;

    // cycles spent in the current phase, restarted at each phase entry
    always_comb begin
        wd_cnt_d   = (first_d || !busy) ? '0 : wd_cnt_q + CW'(1);
        wd_error_d = wd_error_q | timeout;
    end

    // watchdog registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q   <= '0;
            wd_error_q <= 1'b0;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            wd_error_q <= wd_error_d;
        end
    end
`else
    logic unused_timeout_param;
    assign unused_timeout_param = (DONE_TIMEOUT != 0);
    assign timeout  = 1'b0;
    assign wd_error = 1'b0;
`endif

    // move acceptance and phase sequencing
    always_comb begin
        state_d   = state_q;
        first_d   = 1'b0;
        dir_d     = dir_q;
        changed_d = changed_q;
        win_d     = win_q;
        lose_d    = lose_q;
        count_d   = count_q;
        if (accept) begin
            state_d   = SHIFT1;
            first_d   = 1'b1;
            dir_d     = prio_dir;
            changed_d = 1'b0;
        end else if (timeout) begin
            state_d = IDLE;
        end else if (done_ok) begin
            case (state_q)
                SHIFT1: begin
                    state_d   = MERGE;
                    first_d   = 1'b1;
                    changed_d = changed_all;
                end
                MERGE: begin
                    state_d   = SHIFT2;
                    first_d   = 1'b1;
                    changed_d = changed_all;
                end
                SHIFT2: begin
                    state_d   = changed_all ? SPAWN : IDLE;
                    first_d   = changed_all;
                    changed_d = changed_all;
                end
                SPAWN: begin
                    state_d = CHECK;
                    first_d = 1'b1;
                    count_d = (&count_q) ? count_q : count_q + 16'd1;
                end
                CHECK: begin
                    win_d   = win_q | dp_win;
                    lose_d  = lose_q | dp_lose;
                    state_d = (win_q | lose_q | dp_win | dp_lose) ? OVER : IDLE;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // main state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            first_q    <= 1'b0;
            dir_q      <= 2'b00;
            changed_q  <= 1'b0;
            any_prev_q <= 1'b1;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            dir_q      <= dir_d;
            changed_q  <= changed_d;
            any_prev_q <= any_prev_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            count_q    <= count_d;
        end
    end
endmodule
